// File: rtl/aes_spi_sub_port_if.sv
// rtl/aes_spi_sub_port_if.sv - SPI pins and AES core handshake bundle for aes_spi_sub_port
interface aes_spi_sub_port_if;
    logic         cs;
    logic         sclk;
    logic         sdi;
    logic         sdo;
    logic [255:0] key_out;
    logic         key_len;
    logic         key_valid;
    logic [127:0] msg_out;
    logic         msg_valid;
    logic [127:0] result_in;
    logic         result_valid;
    logic         frame_err;

    modport slave (
        input  cs, sclk, sdi, result_in, result_valid,
        output sdo, key_out, key_len, key_valid, msg_out, msg_valid, frame_err
    );

    modport master (
        output cs, sclk, sdi, result_in, result_valid,
        input  sdo, key_out, key_len, key_valid, msg_out, msg_valid, frame_err
    );
endinterface

// File: rtl/aes_spi_sub_port.sv
// rtl/aes_spi_sub_port.sv - oversampled SPI subordinate feeding key/plaintext to the AES core
// Frames: 2-bit header + payload; key -> plaintext -> ciphertext readback sequence.
module aes_spi_sub_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    aes_spi_sub_port_if.slave  bus
);
    typedef enum logic [1:0] {S_KEY = 2'd0, S_MSG = 2'd1, S_RES = 2'd2} state_t;
    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_sdi_sync;
    logic r_cs_d, r_sclk_d;
    logic w_cs, w_sclk, w_sdi;
    logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;

    logic         r_in_frame;
    logic [8:0]   r_bit_cnt;
    logic [1:0]   r_hdr;
    logic [255:0] r_shift;
    logic         r_res_at_start;
    logic         r_res_ready;
    logic [127:0] r_res_q;
    logic [127:0] r_tx;
    logic         r_hdr_fall;
    logic         r_sdo;
    logic [255:0] r_key_out;
    logic         r_key_len;
    logic         r_key_valid;
    logic [127:0] r_msg_out;
    logic         r_msg_valid;
    logic         r_frame_err;

    logic [8:0] w_len;
    logic       w_hdr_bad, w_end, w_ok, w_res_miss;

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
    // r_cs_d resets low, so a frame is only seen after cs has been observed high
    assign w_cs_fall   = r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;
    assign w_sclk_rise = ~r_sclk_d & w_sclk;
    assign w_sclk_fall = r_sclk_d & ~w_sclk;

    always_comb begin
        w_len     = 9'd130;
        w_hdr_bad = 1'b0;
        case (r_state)
            S_KEY: begin
                if (r_hdr == 2'b10)      w_len = 9'd258;
                else if (r_hdr != 2'b00) w_hdr_bad = 1'b1;
            end
            S_MSG:   w_hdr_bad = (r_hdr != 2'b00);
            default: w_hdr_bad = 1'b0;
        endcase
    end

    assign w_end      = r_in_frame & w_cs_rise;
    assign w_ok       = (r_bit_cnt >= w_len) & ~w_hdr_bad;
    assign w_res_miss = (r_state == S_RES) & ~r_res_at_start;

    always_comb begin
        w_state_nxt = r_state;
        if (w_end && w_ok) begin
            case (r_state)
                S_KEY:   w_state_nxt = S_MSG;
                S_MSG:   w_state_nxt = S_RES;
                default: if (r_res_at_start) w_state_nxt = S_KEY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_KEY;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync      <= '0;
            r_sclk_sync    <= '0;
            r_sdi_sync     <= '0;
            r_cs_d         <= 1'b0;
            r_sclk_d       <= 1'b0;
            r_in_frame     <= 1'b0;
            r_bit_cnt      <= '0;
            r_hdr          <= '0;
            r_shift        <= '0;
            r_res_at_start <= 1'b0;
            r_res_ready    <= 1'b0;
            r_res_q        <= '0;
            r_tx           <= '0;
            r_hdr_fall     <= 1'b0;
            r_sdo          <= 1'b0;
            r_key_out      <= '0;
            r_key_len      <= 1'b0;
            r_key_valid    <= 1'b0;
            r_msg_out      <= '0;
            r_msg_valid    <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], bus.sdi};
            r_cs_d      <= w_cs;
            r_sclk_d    <= w_sclk;

            r_key_valid <= w_end & w_ok & (r_state == S_KEY);
            r_msg_valid <= w_end & w_ok & (r_state == S_MSG);
            r_frame_err <= w_end & (~w_ok | w_res_miss);

            if (w_cs_fall) begin
                r_in_frame     <= 1'b1;
                r_bit_cnt      <= '0;
                r_hdr          <= '0;
                r_hdr_fall     <= 1'b0;
                r_sdo          <= 1'b0;
                r_res_at_start <= r_res_ready;
                // Snapshot so a mid-frame result_valid cannot corrupt the readback
                r_tx           <= (r_state == S_RES && r_res_ready) ? r_res_q : '0;
            end else if (w_end) begin
                r_in_frame <= 1'b0;
                r_sdo      <= 1'b0;
                if (w_ok && r_state == S_KEY) begin
                    r_key_len <= (w_len == 9'd258);
                    r_key_out <= (w_len == 9'd258) ? r_shift : {r_shift[127:0], 128'd0};
                end
                if (w_ok && r_state == S_MSG) r_msg_out <= r_shift[127:0];
                if (w_ok && r_state == S_RES && r_res_at_start) r_res_ready <= 1'b0;
            end else if (r_in_frame) begin
                if (w_sclk_rise) begin
                    if (r_bit_cnt != 9'h1FF) r_bit_cnt <= r_bit_cnt + 9'd1;
                    if (r_bit_cnt < 9'd2)         r_hdr   <= {r_hdr[0], w_sdi};
                    else if (r_bit_cnt < w_len)   r_shift <= {r_shift[254:0], w_sdi};
                end
                if (w_sclk_fall) begin
                    if (r_hdr_fall) begin
                        r_sdo <= r_tx[127];
                        r_tx  <= {r_tx[126:0], 1'b0};
                    end else begin
                        r_hdr_fall <= 1'b1;
                    end
                end
            end

            // Placed last so a result arriving with read completion survives the clear
            if (bus.result_valid) begin
                r_res_q     <= bus.result_in;
                r_res_ready <= 1'b1;
            end
        end
    end

    assign bus.sdo       = r_sdo;
    assign bus.key_out   = r_key_out;
    assign bus.key_len   = r_key_len;
    assign bus.key_valid = r_key_valid;
    assign bus.msg_out   = r_msg_out;
    assign bus.msg_valid = r_msg_valid;
    assign bus.frame_err = r_frame_err;
endmodule

// File: doc/aes_spi_sub_port.md
# aes_spi_sub_port

System-clock SPI subordinate port that fronts the AES core: it receives key and plaintext frames from the SPI main, hands them to the core with single-cycle valid strobes, and shifts the ciphertext back on the following read frame. All SPI pins are oversampled in the `clk` domain, so the core and this port share one clock. It is the responder counterpart to the SPI main and replaces the ad-hoc shift logic currently inside the encrypt top level.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `cs`, `sclk` and `sdi`; legal range 2–3.
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: asynchronous, active-high reset.
- `cs` in 1: chip select, active low, asynchronous to `clk`.
- `sclk` in 1: SPI clock, mode 0, asynchronous to `clk`.
- `sdi` in 1: serial data in, MSB first.
- `sdo` out 1: serial data out, MSB first.
- `key_out` out 256: captured key, left-justified; a 128-bit key occupies [255:128] and [127:0] is zero.
- `key_len` out 1: 0 = AES-128, 1 = AES-256.
- `key_valid` out 1: one-cycle pulse; `key_out` and `key_len` are stable from this cycle on.
- `msg_out` out 128: captured plaintext.
- `msg_valid` out 1: one-cycle pulse.
- `result_in` in 128: ciphertext from the core.
- `result_valid` in 1: one-cycle pulse from the core; `result_in` is latched on this pulse.
- `frame_err` out 1: one-cycle pulse on an aborted or illegal frame.

## Operation
- Frame format: a 2-bit header followed by the payload. Header 00 carries a 128-bit payload (130 bits total); header 10 carries a 256-bit payload (258 bits total). Headers 01 and 11 are reserved.
- A frame starts on a `cs` falling edge and ends on a `cs` rising edge. `bit_cnt` is 9 bits and is cleared at frame start. The header is decoded when `bit_cnt` reaches 2.
- Sequencer states:
  - `S_KEY`: the frame is a key. Header 00 or 10 is legal. On completion, update `key_out`/`key_len`, pulse `key_valid`, go to `S_MSG`.
  - `S_MSG`: the frame is plaintext. Only header 00 is legal. On completion, update `msg_out`, pulse `msg_valid`, go to `S_RES`.
  - `S_RES`: the frame is a read. Incoming bits are ignored; length is 130. On completion, go to `S_KEY`, but only if the result was ready at frame start. Otherwise stay in `S_RES` and pulse `frame_err`.
- `res_ready` is set on `result_valid` and cleared when a read frame completes. A `result_valid` pulse in any state latches `result_in`.
- `sdo` drives 0 for the two header bit times, then `res_q[127:0]` MSB first.
  - `sdo` is 0 outside `S_RES`, when `cs` is high, and when `res_ready` was 0 at frame start.
- Error cases, each of which pulses `frame_err`, discards the frame and leaves the state unchanged:
  - `cs` rises with `bit_cnt` below the frame length.
  - A reserved header is received, or header 10 arrives in `S_MSG`.
- Bits beyond the frame length are ignored; the frame completes at the `cs` rising edge.
- Payload shift registers are separate from the `key_out`/`msg_out` holding registers, so a discarded frame never alters the outputs.
- Reset: state is `S_KEY`, all registers are 0, `res_ready` is 0. Mid-frame reset aborts silently with no `frame_err`. The next frame is recognised only after `cs` is seen high and then falls.

## Timing
- Every synchronized input lags its pin by `SYNC_STAGES` cycles. Edge detect adds one more register.
- `sclk` high and low times must each be at least `SYNC_STAGES`+2 `clk` cycles. The bench uses an sclk period of 8 `clk`.
- `sdi` is sampled on the detected `sclk` rising edge.
- `sdo` updates one `clk` after the detected `sclk` falling edge. The first payload bit is driven after the second header falling edge.
- Valid pulses fire exactly one `clk` after the detected `cs` rising edge of a complete frame.
- Simultaneous `result_valid` and read-frame completion: the completion clears `res_ready` first, then the new result sets it. The new result is held for the next read.
- Every output has a reset value of 0.

## Test plan
- Key frame {2'b00, 128'h000102030405060708090a0b0c0d0e0f} -> `key_valid` pulses once, `key_out[255:128]` = that key, `key_len` = 0, state `S_MSG`.
- Plaintext frame {2'b00, 128'h00112233445566778899aabbccddeeff}, then `result_valid` with 128'h69c4e0d86a7b0430d8cdb78070b4c55a, then a 130-bit all-zero read frame -> main receives 69c4e0d8…b4c55a; state returns to `S_KEY`.
- Key frame {2'b10, 256'h000102…1e1f}, then the same plaintext, then result 128'h8ea2b7ca516745bfeafc49904b496089 -> `key_len` = 1, `key_out` = full 256-bit key, readback matches the result.
- `cs` raised after 70 bits of a key frame -> `frame_err` pulses, no `key_valid`, `key_out` unchanged; the following full key frame is accepted.
- Read frame issued before `result_valid` -> `sdo` is all zeros, `frame_err` pulses, state stays `S_RES`. After `result_valid`, the retried read returns the result.
- `rst` asserted at bit 60 of a plaintext frame -> all outputs are 0, state `S_KEY`, no pulses. The next complete key frame is accepted.
